// File: rtl/execute_stage.sv
// Y86-64 execute stage: E register, ALU, condition codes and branch/cmov condition.
// Optional EXC_CC_GUARD_EN: block CC writes while M or W holds an exception.
module execute_stage #(
    parameter int         WIDTH    = 64,
    parameter logic [2:0] RESET_CC = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             E_stall,
    input  logic             E_bubble,
    input  logic [2:0]       d_stat,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_ifun,
    input  logic [WIDTH-1:0] d_valC,
    input  logic [WIDTH-1:0] d_valA,
    input  logic [WIDTH-1:0] d_valB,
    input  logic [3:0]       d_dstE,
    input  logic [3:0]       d_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             m_stat_exc,
    input  logic             W_stat_exc,
    output logic [WIDTH-1:0] e_valE,
    output logic             e_Cnd,
    output logic [3:0]       e_dstE,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_dstM,
    output logic [3:0]       E_srcA,
    output logic [3:0]       E_srcB,
    output logic [WIDTH-1:0] E_valA,
    output logic [2:0]       E_stat,
    output logic [2:0]       cc_out
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h1;
    localparam logic [3:0] F_AND = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [2:0] S_AOK = 3'd1;

    localparam logic [WIDTH-1:0] POS8 = WIDTH'(8);
    localparam logic [WIDTH-1:0] NEG8 = ~WIDTH'(7);

    typedef struct packed {
        logic [2:0]       stat;
        logic [3:0]       icode;
        logic [3:0]       ifun;
        logic [WIDTH-1:0] valc;
        logic [WIDTH-1:0] vala;
        logic [WIDTH-1:0] valb;
        logic [3:0]       dste;
        logic [3:0]       dstm;
        logic [3:0]       srca;
        logic [3:0]       srcb;
    } e_reg_t;

    localparam e_reg_t E_NOP = '{
        stat:  S_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        valc:  '0,
        vala:  '0,
        valb:  '0,
        dste:  RNONE,
        dstm:  RNONE,
        srca:  RNONE,
        srcb:  RNONE
    };

    e_reg_t e_q;
    e_reg_t e_d;

    always_comb begin
        e_d = e_q;
        if (E_bubble) begin
            e_d = E_NOP;
        end else if (!E_stall) begin
            e_d = '{
                stat:  d_stat,
                icode: d_icode,
                ifun:  d_ifun,
                valc:  d_valC,
                vala:  d_valA,
                valb:  d_valB,
                dste:  d_dstE,
                dstm:  d_dstM,
                srca:  d_srcA,
                srcb:  d_srcB
            };
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q <= E_NOP;
        end else begin
            e_q <= e_d;
        end
    end

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (e_q.icode)
            I_RRMOVQ: begin
                alu_a = e_q.vala;
            end
            I_IRMOVQ: begin
                alu_a = e_q.valc;
            end
            I_RMMOVQ, I_MRMOVQ: begin
                alu_a = e_q.valc;
                alu_b = e_q.valb;
            end
            I_OPQ: begin
                alu_a = e_q.vala;
                alu_b = e_q.valb;
            end
            I_CALL, I_PUSHQ: begin
                alu_a = NEG8;
                alu_b = e_q.valb;
            end
            I_RET, I_POPQ: begin
                alu_a = POS8;
                alu_b = e_q.valb;
            end
            default: ;
        endcase
    end

    logic [3:0] alufun;
    logic       is_add;
    logic       is_sub;
    logic       is_and;
    logic       is_xor;

    assign alufun = (e_q.icode == I_OPQ) ? e_q.ifun : F_ADD;
    assign is_add = (alufun == F_ADD);
    assign is_sub = (alufun == F_SUB);
    assign is_and = (alufun == F_AND);
    assign is_xor = (alufun == F_XOR);

    // Split the adder at the MSB so carry-in and carry-out of the sign bit
    // are both visible for the overflow flag.
    logic [WIDTH-1:0] a_add;
    logic [WIDTH-1:0] low_sum;
    logic [1:0]       top_sum;
    logic             c_msb;
    logic             c_out;
    logic [WIDTH-1:0] arith_sum;

    assign a_add   = is_sub ? ~alu_a : alu_a;
    assign low_sum = {1'b0, alu_b[WIDTH-2:0]}
                   + {1'b0, a_add[WIDTH-2:0]}
                   + {{(WIDTH-1){1'b0}}, is_sub};
    assign c_msb   = low_sum[WIDTH-1];
    assign top_sum = 2'(alu_b[WIDTH-1]) + 2'(a_add[WIDTH-1]) + 2'(c_msb);
    assign c_out   = top_sum[1];
    assign arith_sum = {top_sum[0], low_sum[WIDTH-2:0]};

    logic [WIDTH-1:0] alu_res;
    logic             alu_of;

    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        unique case (1'b1)
            is_add, is_sub: begin
                alu_res = arith_sum;
                alu_of  = c_msb ^ c_out;
            end
            is_and: begin
                alu_res = alu_a & alu_b;
            end
            is_xor: begin
                alu_res = alu_a ^ alu_b;
            end
            default: ;
        endcase
    end

    logic alu_zf;
    logic alu_sf;

    assign alu_zf = (alu_res == '0);
    assign alu_sf = alu_res[WIDTH-1];

    logic set_cc;

`ifdef EXC_CC_GUARD_EN
    assign set_cc = (e_q.icode == I_OPQ) && (e_q.stat == S_AOK)
                 && !m_stat_exc && !W_stat_exc;
`else
    logic unused_exc;
    assign unused_exc = m_stat_exc | W_stat_exc;
    assign set_cc = (e_q.icode == I_OPQ) && (e_q.stat == S_AOK);
`endif

    logic [2:0] cc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_q <= RESET_CC;
        end else if (set_cc) begin
            cc_q <= {alu_zf, alu_sf, alu_of};
        end
    end

    logic zf;
    logic sf;
    logic of;
    logic cnd;

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    always_comb begin
        cnd = 1'b0;
        case (e_q.ifun)
            4'h0: cnd = 1'b1;
            4'h1: cnd = (sf ^ of) | zf;
            4'h2: cnd = sf ^ of;
            4'h3: cnd = zf;
            4'h4: cnd = !zf;
            4'h5: cnd = !(sf ^ of);
            4'h6: cnd = !(sf ^ of) && !zf;
            default: cnd = 1'b0;
        endcase
    end

    assign e_valE  = alu_res;
    assign e_Cnd   = cnd;
    assign e_dstE  = ((e_q.icode == I_RRMOVQ) && !cnd) ? RNONE : e_q.dste;
    assign E_icode = e_q.icode;
    assign E_dstM  = e_q.dstm;
    assign E_srcA  = e_q.srca;
    assign E_srcB  = e_q.srcb;
    assign E_valA  = e_q.vala;
    assign E_stat  = e_q.stat;
    assign cc_out  = cc_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with a cycle-level behavioural model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        E_stall = 1'b0;
    logic        E_bubble = 1'b0;
    logic [2:0]  d_stat = 3'd1;
    logic [3:0]  d_icode = 4'h1;
    logic [3:0]  d_ifun = 4'h0;
    logic [63:0] d_valC = '0;
    logic [63:0] d_valA = '0;
    logic [63:0] d_valB = '0;
    logic [3:0]  d_dstE = 4'hF;
    logic [3:0]  d_dstM = 4'hF;
    logic [3:0]  d_srcA = 4'hF;
    logic [3:0]  d_srcB = 4'hF;
    logic        m_stat_exc = 1'b0;
    logic        W_stat_exc = 1'b0;
    logic [63:0] e_valE;
    logic        e_Cnd;
    logic [3:0]  e_dstE;
    logic [3:0]  E_icode;
    logic [3:0]  E_dstM;
    logic [3:0]  E_srcA;
    logic [3:0]  E_srcB;
    logic [63:0] E_valA;
    logic [2:0]  E_stat;
    logic [2:0]  cc_out;

    execute_stage #(.WIDTH(64), .RESET_CC(3'b100)) dut (
        .clk(clk), .rst_n(rst_n), .E_stall(E_stall), .E_bubble(E_bubble),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
        .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .m_stat_exc(m_stat_exc), .W_stat_exc(W_stat_exc),
        .e_valE(e_valE), .e_Cnd(e_Cnd), .e_dstE(e_dstE),
        .E_icode(E_icode), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .E_valA(E_valA), .E_stat(E_stat), .cc_out(cc_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
    } ereg_t;

    ereg_t      me;
    logic [2:0] mcc;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ereg_t nop_reg();
        ereg_t r;
        r.stat = 3'd1; r.icode = 4'h1; r.ifun = 4'h0;
        r.valc = '0; r.vala = '0; r.valb = '0;
        r.dste = 4'hF; r.dstm = 4'hF; r.srca = 4'hF; r.srcb = 4'hF;
        return r;
    endfunction

    // Returns {OF, result}; overflow from operand/result signs.
    function automatic logic [64:0] mdl_alu(input ereg_t e);
        logic [63:0] a, b, r;
        logic        ov;
        logic [3:0]  fun;
        a = '0; b = '0; r = '0; ov = 1'b0;
        case (e.icode)
            4'h2: a = e.vala;
            4'h3: a = e.valc;
            4'h4, 4'h5: begin a = e.valc; b = e.valb; end
            4'h6: begin a = e.vala; b = e.valb; end
            4'h8, 4'hA: begin a = 64'hFFFF_FFFF_FFFF_FFF8; b = e.valb; end
            4'h9, 4'hB: begin a = 64'd8; b = e.valb; end
            default: ;
        endcase
        fun = (e.icode == 4'h6) ? e.ifun : 4'h0;
        case (fun)
            4'h0: begin
                r = b + a;
                ov = (a[63] == b[63]) && (r[63] != a[63]);
            end
            4'h1: begin
                r = b - a;
                ov = (a[63] != b[63]) && (r[63] != b[63]);
            end
            4'h2: r = a & b;
            4'h3: r = a ^ b;
            default: r = '0;
        endcase
        return {ov, r};
    endfunction

    function automatic logic mdl_cnd(input logic [3:0] f, input logic [2:0] cc);
        logic z, s, o;
        z = cc[2]; s = cc[1]; o = cc[0];
        case (f)
            4'h0: return 1'b1;
            4'h1: return (s != o) || z;
            4'h2: return s != o;
            4'h3: return z;
            4'h4: return !z;
            4'h5: return s == o;
            4'h6: return (s == o) && !z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        logic [64:0] r;
        logic        guard_ok;
        if (!rst_n) begin
            mcc = 3'b100;
            me = nop_reg();
        end else begin
            r = mdl_alu(me);
            guard_ok = 1'b1;
`ifdef EXC_CC_GUARD_EN
            guard_ok = !m_stat_exc && !W_stat_exc;
`endif
            if (me.icode == 4'h6 && me.stat == 3'd1 && guard_ok)
                mcc = {r[63:0] == 64'd0, r[63], r[64]};
            if (E_bubble) begin
                me = nop_reg();
            end else if (!E_stall) begin
                me.stat = d_stat; me.icode = d_icode; me.ifun = d_ifun;
                me.valc = d_valC; me.vala = d_valA; me.valb = d_valB;
                me.dste = d_dstE; me.dstm = d_dstM;
                me.srca = d_srcA; me.srcb = d_srcB;
            end
        end
    endtask

    logic [64:0] cp_r;
    logic        cp_c;

    always @(negedge clk) begin
        if (chk_en) begin
            cp_r = mdl_alu(me);
            cp_c = mdl_cnd(me.ifun, mcc);
            check("m_valE", e_valE, cp_r[63:0]);
            check("m_Cnd", 64'(e_Cnd), 64'(cp_c));
            check("m_dstE", 64'(e_dstE),
                  64'((me.icode == 4'h2 && !cp_c) ? 4'hF : me.dste));
            check("m_icode", 64'(E_icode), 64'(me.icode));
            check("m_dstM", 64'(E_dstM), 64'(me.dstm));
            check("m_srcA", 64'(E_srcA), 64'(me.srca));
            check("m_srcB", 64'(E_srcB), 64'(me.srcb));
            check("m_valA", E_valA, me.vala);
            check("m_stat", 64'(E_stat), 64'(me.stat));
            check("m_cc", 64'(cc_out), 64'(mcc));
        end
    end

    task automatic drv(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] c, input logic [63:0] a,
                       input logic [63:0] b, input logic [3:0] de);
        d_stat = 3'd1; d_icode = ic; d_ifun = fn;
        d_valC = c; d_valA = a; d_valB = b;
        d_dstE = de; d_dstM = 4'h7; d_srcA = 4'h3; d_srcB = de;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    logic [63:0] opa [6] = '{64'h8000_0000_0000_0000, 64'h1, 64'hF0F0,
                             64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'h1234_5678};
    logic [63:0] opb [6] = '{64'h1, 64'h8000_0000_0000_0000, 64'h0FF0,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1234_5678};

    initial begin
        me = nop_reg();
        mcc = 3'b100;
        rst_n = 1'b0;
        drv(4'h6, 4'h0, 64'h5, 64'h9, 64'h9, 4'h2);
        step();
        chk_en = 1'b1;
        check("rst_icode", 64'(E_icode), 64'h1);
        check("rst_stat", 64'(E_stat), 64'h1);
        check("rst_dstM", 64'(E_dstM), 64'hF);
        check("rst_srcA", 64'(E_srcA), 64'hF);
        check("rst_srcB", 64'(E_srcB), 64'hF);
        check("rst_dstE", 64'(e_dstE), 64'hF);
        check("rst_cc", 64'(cc_out), 64'h4);
        rst_n = 1'b1;

        drv(4'h6, 4'h1, 0, 64'd5, 64'd3, 4'h3); step();
        check("subq_val", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        drv(4'h6, 4'h0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h4);
        step();
        check("subq_cc", 64'(cc_out), 64'h2);
        check("addov_val", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        drv(4'h6, 4'h3, 0, 64'h1234, 64'h1234, 4'h5); step();
        check("addov_cc", 64'(cc_out), 64'h3);
        check("xor_val", e_valE, 64'h0);
        drv(4'h6, 4'h0, 0, 64'd1, 64'd1, 4'h6); step();
        check("xor_cc", 64'(cc_out), 64'h4);
        drv(4'h2, 4'h1, 0, 64'h55, 0, 4'h7); step();
        check("cmov_cc", 64'(cc_out), 64'h0);
        check("cmovle_cnd", 64'(e_Cnd), 64'h0);
        check("cmovle_dstE", 64'(e_dstE), 64'hF);
        check("cmov_val", e_valE, 64'h55);
        drv(4'h6, 4'h3, 0, 64'd9, 64'd9, 4'h5); step();
        drv(4'h7, 4'h1, 64'h400, 0, 0, 4'hF); step();
        check("jle_cc", 64'(cc_out), 64'h4);
        check("jle_cnd", 64'(e_Cnd), 64'h1);
        drv(4'h2, 4'h1, 0, 64'h66, 0, 4'h7); step();
        check("cmov_take", 64'(e_dstE), 64'h7);
        drv(4'hA, 4'h0, 0, 64'hAA, 64'h100, 4'h4); step();
        check("push_val", e_valE, 64'hF8);

        E_stall = 1'b1;
        drv(4'h6, 4'h0, 0, 64'd1, 64'd2, 4'h3); step();
        check("stall_icode", 64'(E_icode), 64'hA);
        check("stall_valA", E_valA, 64'hAA);
        E_bubble = 1'b1;
        drv(4'h6, 4'h1, 0, 64'd7, 64'd2, 4'h3); step();
        check("sb_icode", 64'(E_icode), 64'h1);
        check("sb_cc", 64'(cc_out), 64'h4);
        E_stall = 1'b0; E_bubble = 1'b0;
        drv(4'h1, 4'h0, 0, 0, 0, 4'hF); step();
        check("sb_cc2", 64'(cc_out), 64'h4);

        drv(4'hB, 4'h0, 0, 0, 64'h100, 4'h4); step();
        check("pop_val", e_valE, 64'h108);
        drv(4'h8, 4'h0, 64'h800, 0, 64'h200, 4'h4); step();
        check("call_val", e_valE, 64'h1F8);
        drv(4'h9, 4'h0, 0, 0, 64'h1F8, 4'h4); step();
        drv(4'h4, 4'h0, 64'h10, 0, 64'h20, 4'hF); step();
        check("rmmov_val", e_valE, 64'h30);
        drv(4'h3, 4'h0, 64'h77, 0, 64'h20, 4'h2); step();
        check("irmov_val", e_valE, 64'h77);

        drv(4'h6, 4'h0, 0, 64'd1, 64'd1, 4'h3); step();
        m_stat_exc = 1'b1;
        drv(4'h1, 4'h0, 0, 0, 0, 4'hF); step();
`ifdef EXC_CC_GUARD_EN
        check("guard_cc", 64'(cc_out), 64'h4);
`else
        check("guard_cc", 64'(cc_out), 64'h0);
`endif
        m_stat_exc = 1'b0;

        drv(4'h6, 4'h4, 0, 64'd5, 64'd7, 4'h3); step();
        check("badfn_val", e_valE, 64'h0);
        drv(4'h1, 4'h0, 0, 0, 0, 4'hF); step();
        check("badfn_cc", 64'(cc_out), 64'h4);
        drv(4'h6, 4'h1, 0, 64'd5, 64'd3, 4'h3);
        d_stat = 3'd3;
        step();
        check("adr_stat", 64'(E_stat), 64'h3);
        drv(4'h1, 4'h0, 0, 0, 0, 4'hF); step();
        check("adr_cc", 64'(cc_out), 64'h4);

        for (int i = 0; i < 6; i++) begin
            for (int f = 0; f < 4; f++) begin
                drv(4'h6, 4'(f), 0, opa[i], opb[i], 4'h2); step();
                drv(4'h7, 4'(i + f), 64'h40, 0, 0, 4'hF); step();
                drv(4'h2, 4'(f + 1), 0, opa[i], 0, 4'h5); step();
            end
        end
        for (int f = 0; f < 16; f++) begin
            drv(4'h7, 4'(f), 64'h80, 0, 0, 4'hF); step();
        end

        drv(4'h6, 4'h1, 0, 64'd5, 64'd3, 4'h3); step();
        rst_n = 1'b0;
        drv(4'h6, 4'h0, 0, 64'd1, 64'd1, 4'h3); step();
        check("mrst_icode", 64'(E_icode), 64'h1);
        check("mrst_cc", 64'(cc_out), 64'h4);
        rst_n = 1'b1;
        drv(4'h1, 4'h0, 0, 0, 0, 4'hF); step();
        step();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
